// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream valid/ready entry, downstream valid/ready entry,
// flush and occupancy. The stage itself takes the slave side.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        level;

  modport master (
    output in_valid,
    output in_data,
    output in_ctrl,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ctrl,
    input  level
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_ctrl,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ctrl,
    output level
  );

endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer, flush, and a selectable
// active clock edge. Control bits read as zero whenever the stage presents no entry.
module pipe_stage_reg #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned CTRL_W  = 8,
  parameter int unsigned SKID    = 1,
  parameter int unsigned NEGEDGE = 1
) (
  input logic             CLK,
  input logic             RST_N,
  pipe_stage_reg_if.slave bus
);

  // Encoding equals the held-entry count, so level is the state itself.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  logic out_valid;
  logic in_ready;
  logic push;
  logic pop;

  assign out_valid     = (state_q != StEmpty);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head_data_q;
  assign bus.out_ctrl  = out_valid ? head_ctrl_q : '0;
  assign bus.level     = state_q;
  assign bus.in_ready  = in_ready;

  // Skid mode keeps in_ready registered to cut the out_ready -> in_ready path.
  always_comb begin
    in_ready = 1'b0;
    if (SKID != 0) begin
      in_ready = in_ready_q;
    end else begin
      in_ready = !out_valid || bus.out_ready;
    end
  end

  assign push = bus.in_valid && in_ready;
  assign pop  = out_valid && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_ctrl_d = head_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (bus.flush) begin
      // A simultaneous pop still completes downstream; the incoming entry is dropped.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            state_d     = StOne;
            head_data_d = bus.in_data;
            head_ctrl_d = bus.in_ctrl;
          end
        end
        StOne: begin
          if (push && pop) begin
            head_data_d = bus.in_data;
            head_ctrl_d = bus.in_ctrl;
          end else if (push) begin
            state_d     = StFull;
            skid_data_d = bus.in_data;
            skid_ctrl_d = bus.in_ctrl;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            state_d     = StOne;
            head_data_d = skid_data_q;
            head_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d = StEmpty;
        end
      endcase
    end

    in_ready_d = (state_d != StFull);
  end

  if (NEGEDGE != 0) begin : g_neg
    always_ff @(negedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_q     <= StEmpty;
        in_ready_q  <= 1'b1;
        head_data_q <= '0;
        head_ctrl_q <= '0;
        skid_data_q <= '0;
        skid_ctrl_q <= '0;
      end else begin
        state_q     <= state_d;
        in_ready_q  <= in_ready_d;
        head_data_q <= head_data_d;
        head_ctrl_q <= head_ctrl_d;
        skid_data_q <= skid_data_d;
        skid_ctrl_q <= skid_ctrl_d;
      end
    end
  end else begin : g_pos
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state_q     <= StEmpty;
        in_ready_q  <= 1'b1;
        head_data_q <= '0;
        head_ctrl_q <= '0;
        skid_data_q <= '0;
        skid_ctrl_q <= '0;
      end else begin
        state_q     <= state_d;
        in_ready_q  <= in_ready_d;
        head_data_q <= head_data_d;
        head_ctrl_q <= head_ctrl_d;
        skid_data_q <= skid_data_d;
        skid_ctrl_q <= skid_ctrl_d;
      end
    end
  end

  // Without the skid buffer the stage can never hold two entries.
  a_no_full_without_skid : assert property (@(posedge CLK) disable iff (!RST_N)
    (SKID != 0) || (state_q != StFull));

  a_ready_matches_state : assert property (@(posedge CLK) disable iff (!RST_N)
    (SKID == 0) || (in_ready_q == (state_q != StFull)));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: dut_a is skid/falling-edge, dut_b is single-register/rising-edge.
module tb_pipe_stage_reg;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  logic [71:0] qa[$];
  logic [71:0] qb[$];

  pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(8)) a_if ();
  pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(8)) b_if ();

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1), .NEGEDGE(1)) dut_a (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (a_if)
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(0), .NEGEDGE(0)) dut_b (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // dut_a updates on falling edges: drive just after the rising edge.
  task automatic edge_a();
    @(posedge clk);
    #1;
  endtask

  task automatic edge_b();
    @(negedge clk);
    #1;
  endtask

  // Monitors sample midway between drive time and the next active edge.
  initial begin
    logic [71:0] e;
    forever begin
      @(posedge clk);
      #3;
      if (rst_n && a_if.out_valid && a_if.out_ready) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_out: got %0h expected none", a_if.out_data);
        end else begin
          e = qa.pop_front();
          check("a_out", {a_if.out_data, a_if.out_ctrl}, e);
        end
      end
    end
  end

  initial begin
    logic [71:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && b_if.out_valid && b_if.out_ready) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_out: got %0h expected none", b_if.out_data);
        end else begin
          e = qb.pop_front();
          check("b_out", {b_if.out_data, b_if.out_ctrl}, e);
        end
      end
    end
  end

  task automatic drive_a(input logic v, input logic [63:0] d, input logic [7:0] c);
    a_if.in_valid = v;
    a_if.in_data  = d;
    a_if.in_ctrl  = c;
  endtask

  task automatic drive_b(input logic v, input logic [63:0] d, input logic [7:0] c);
    b_if.in_valid = v;
    b_if.in_data  = d;
    b_if.in_ctrl  = c;
  endtask

  initial begin
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    a_if.flush = 1'b0;
    b_if.flush = 1'b0;
    a_if.out_ready = 1'b0;
    b_if.out_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("a_rst_in_ready", a_if.in_ready, 1'b1);
    check("a_rst_out_valid", a_if.out_valid, 1'b0);
    check("a_rst_level", a_if.level, 2'd0);
    check("a_rst_out_ctrl", a_if.out_ctrl, 8'h00);
    check("a_rst_out_data", a_if.out_data, 64'h0);
    check("b_rst_in_ready", b_if.in_ready, 1'b1);
    check("b_rst_level", b_if.level, 2'd0);
    edge_a();
    rst_n = 1'b1;

    // Bubbles: ctrl presented without valid must never reach out_ctrl.
    for (int i = 0; i < 10; i++) begin
      edge_a();
      drive_a(1'b0, 64'h1234, 8'hFF);
      #1;
      check("a_bubble_valid", a_if.out_valid, 1'b0);
      check("a_bubble_ctrl", a_if.out_ctrl, 8'h00);
    end

    // Streaming at full rate.
    a_if.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      edge_a();
      drive_a(1'b1, 64'(k), 8'(8'h10 + k));
      qa.push_back({64'(k), 8'(8'h10 + k)});
      #1;
      check("a_stream_in_ready", a_if.in_ready, 1'b1);
      if (k > 1) check("a_stream_level", a_if.level, 2'd1);
    end
    edge_a();
    drive_a(1'b0, '0, '0);
    #1 check("a_stream_level_tail", a_if.level, 2'd1);
    edge_a();
    #1 check("a_stream_drained", a_if.level, 2'd0);

    // Backpressure: A and B fill the stage, C waits upstream.
    a_if.out_ready = 1'b0;
    edge_a();
    drive_a(1'b1, 64'hA, 8'h2A);
    qa.push_back({64'hA, 8'h2A});
    #1 check("a_bp_level0", a_if.level, 2'd0);
    edge_a();
    drive_a(1'b1, 64'hB, 8'h2B);
    qa.push_back({64'hB, 8'h2B});
    #1 check("a_bp_level1", a_if.level, 2'd1);
    edge_a();
    drive_a(1'b1, 64'hC, 8'h2C);
    qa.push_back({64'hC, 8'h2C});
    #1;
    check("a_bp_level2", a_if.level, 2'd2);
    check("a_bp_in_ready0", a_if.in_ready, 1'b0);
    edge_a();
    #1;
    check("a_bp_hold_level", a_if.level, 2'd2);
    check("a_bp_hold_ready", a_if.in_ready, 1'b0);
    check("a_bp_head", a_if.out_data, 64'hA);
    edge_a();
    a_if.out_ready = 1'b1;
    #1 check("a_bp_release_level", a_if.level, 2'd2);
    edge_a();
    #1;
    check("a_bp_after_pop_level", a_if.level, 2'd1);
    check("a_bp_after_pop_ready", a_if.in_ready, 1'b1);
    edge_a();
    drive_a(1'b0, '0, '0);
    #1 check("a_bp_c_level", a_if.level, 2'd1);
    edge_a();
    #1 check("a_bp_drained", a_if.level, 2'd0);

    // Flush while full with D offered: nothing held or offered survives.
    a_if.out_ready = 1'b0;
    edge_a();
    drive_a(1'b1, 64'hE1, 8'h31);
    edge_a();
    drive_a(1'b1, 64'hE2, 8'h32);
    edge_a();
    drive_a(1'b1, 64'hD, 8'h3D);
    a_if.flush = 1'b1;
    #1 check("a_fl_level_before", a_if.level, 2'd2);
    edge_a();
    a_if.flush = 1'b0;
    drive_a(1'b0, '0, '0);
    #1;
    check("a_fl_level", a_if.level, 2'd0);
    check("a_fl_out_valid", a_if.out_valid, 1'b0);
    check("a_fl_out_ctrl", a_if.out_ctrl, 8'h00);
    a_if.out_ready = 1'b1;
    repeat (3) edge_a();

    // Flush with one held entry: it still leaves, the offered D2 is dropped.
    a_if.out_ready = 1'b0;
    edge_a();
    drive_a(1'b1, 64'hE3, 8'h33);
    qa.push_back({64'hE3, 8'h33});
    edge_a();
    drive_a(1'b1, 64'hDD2, 8'h3E);
    a_if.flush = 1'b1;
    a_if.out_ready = 1'b1;
    #1 check("a_fl1_in_ready", a_if.in_ready, 1'b1);
    edge_a();
    a_if.flush = 1'b0;
    drive_a(1'b0, '0, '0);
    #1 check("a_fl1_level", a_if.level, 2'd0);
    repeat (3) edge_a();

    // Asynchronous reset while full, then a transfer on the first edge after release.
    a_if.out_ready = 1'b0;
    edge_a();
    drive_a(1'b1, 64'h71, 8'h41);
    edge_a();
    drive_a(1'b1, 64'h72, 8'h42);
    edge_a();
    drive_a(1'b0, '0, '0);
    #1 check("a_rst_mid_level_before", a_if.level, 2'd2);
    rst_n = 1'b0;
    #1;
    check("a_rst_mid_valid", a_if.out_valid, 1'b0);
    check("a_rst_mid_level", a_if.level, 2'd0);
    check("a_rst_mid_ctrl", a_if.out_ctrl, 8'h00);
    check("a_rst_mid_ready", a_if.in_ready, 1'b1);
    edge_a();
    rst_n = 1'b1;
    drive_a(1'b1, 64'h6, 8'h46);
    a_if.out_ready = 1'b1;
    qa.push_back({64'h6, 8'h46});
    edge_a();
    drive_a(1'b0, '0, '0);
    #1;
    check("a_post_rst_level", a_if.level, 2'd1);
    check("a_post_rst_head", a_if.out_data, 64'h6);
    edge_a();
    #1 check("a_post_rst_drained", a_if.level, 2'd0);

    // Single-register stage, rising edge: streaming.
    b_if.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      edge_b();
      drive_b(1'b1, 64'(256 + k), 8'(8'h40 + k));
      qb.push_back({64'(256 + k), 8'(8'h40 + k)});
      #1;
      check("b_stream_in_ready", b_if.in_ready, 1'b1);
      if (k > 1) check("b_stream_level", b_if.level, 2'd1);
    end
    edge_b();
    drive_b(1'b0, '0, '0);
    #1 check("b_stream_level_tail", b_if.level, 2'd1);
    edge_b();
    #1 check("b_stream_drained", b_if.level, 2'd0);

    // Stalled E blocks F; releasing out_ready swaps E out and F in on one edge.
    b_if.out_ready = 1'b0;
    edge_b();
    drive_b(1'b1, 64'hE, 8'h5E);
    qb.push_back({64'hE, 8'h5E});
    #1 check("b_e_in_ready", b_if.in_ready, 1'b1);
    edge_b();
    drive_b(1'b1, 64'hF, 8'h5F);
    qb.push_back({64'hF, 8'h5F});
    #1;
    check("b_stall_in_ready", b_if.in_ready, 1'b0);
    check("b_stall_level", b_if.level, 2'd1);
    edge_b();
    b_if.out_ready = 1'b1;
    #1;
    check("b_pass_in_ready", b_if.in_ready, 1'b1);
    check("b_pass_head", b_if.out_data, 64'hE);
    edge_b();
    drive_b(1'b0, '0, '0);
    #1;
    check("b_f_head", b_if.out_data, 64'hF);
    check("b_f_level", b_if.level, 2'd1);
    edge_b();
    #1 check("b_drained", b_if.level, 2'd0);

    repeat (2) edge_a();
    check("a_queue_empty", 72'(qa.size()), 72'd0);
    check("b_queue_empty", 72'(qb.size()), 72'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64, payload bits (data path, e.g. ALU result plus read data) carried unmodified.
REQ-002 Parameter CTRL_W, default 8, control bits (write enables, mux selects, destination register) carried and zeroed on bubbles.
REQ-003 Parameter SKID, default 1, 1 = two-entry skid buffer, 0 = single register with combinational ready pass-through.
REQ-004 Parameter NEGEDGE, default 1, 1 = all state updates on falling CLK edge, 0 = on rising edge.
REQ-005 CLK  input  1  stage clock; the only clock.
REQ-006 RST_N  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  stage accepts an entry at the next active edge.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 in_ctrl  input  CTRL_W  upstream control bits.
REQ-011 flush  input  1  synchronous discard of all held entries.
REQ-012 out_valid  output  1  downstream entry present.
REQ-013 out_ready  input  1  downstream consumes the entry at the next active edge.
REQ-014 out_data  output  DATA_W  head-entry payload.
REQ-015 out_ctrl  output  CTRL_W  head-entry control bits; all zero whenever out_valid = 0.
REQ-016 level  output  2  held-entry count, 0..2.

Function
REQ-017 Only the edge selected by NEGEDGE updates state; RST_N acts immediately regardless of CLK.
REQ-018 Transfer in = in_valid & in_ready at an active edge; transfer out = out_valid & out_ready at an active edge.
REQ-019 SKID=1 states: EMPTY (level 0), ONE (head full), FULL (head + skid full).
REQ-020 EMPTY: transfer in -> ONE, head loaded.
REQ-021 ONE: in only -> FULL, skid loaded; out only -> EMPTY; in and out -> ONE, head loaded with new entry; neither -> ONE.
REQ-022 FULL: out -> ONE, skid moves to head; no transfer in is possible.
REQ-023 SKID=1: in_ready = 1 in EMPTY and ONE, 0 in FULL; registered, with no combinational path from out_ready.
REQ-024 SKID=0: single entry; in_ready = !out_valid | out_ready (combinational); level never exceeds 1.
REQ-025 Latency: an entry accepted at edge N appears on out_* after edge N when the stage was empty (one-edge latency); throughput is one entry per edge while out_ready = 1.
REQ-026 Ordering is strict FIFO; no entry is duplicated, dropped or reordered except by flush.
REQ-027 out_valid = (level != 0); out_data is don't-care and out_ctrl = 0 when out_valid = 0.
REQ-028 flush = 1 at an active edge: next state EMPTY and level = 0; any simultaneous transfer in is discarded; a simultaneous transfer out completes downstream as normal.
REQ-029 in_ready during flush follows REQ-023/REQ-024 for the current state; the discarded entry is not re-presented by this block.
REQ-030 Payload registers load only on accepting edges (no toggling while stalled).

Reset
REQ-031 RST_N = 0: state EMPTY, level = 0, out_valid = 0, out_ctrl = 0, out_data = 0, in_ready = 1, asynchronously.
REQ-032 Deassertion of RST_N mid-operation leaves the stage EMPTY; the first transfer is possible at the first active edge after release.

Verification
REQ-033 Reset: assert RST_N = 0 between edges while FULL -> out_valid, level and out_ctrl go to 0 without a clock edge; in_ready = 1.
REQ-034 Streaming: out_ready = 1, in_data = 1,2,3,4 on consecutive edges -> out_data = 1,2,3,4 one edge later each; level stays 1; in_ready stays 1.
REQ-035 Backpressure (SKID=1): out_ready = 0, push A,B,C -> A, B accepted, level = 2, in_ready = 0, C held upstream; out_ready = 1 -> out_data A, B, C in order.
REQ-036 Flush: level = 2, flush = 1 with in_valid = 1 (D) -> next edge level = 0, out_valid = 0, out_ctrl = 0, and D never appears.
REQ-037 SKID=0 with NEGEDGE=0: out_ready = 0 while holding E -> in_ready = 0; out_ready = 1 with F offered -> E leaves and F loads on the same rising edge.
REQ-038 Bubble: EMPTY, in_ctrl = 8'hFF, in_valid = 0 -> out_ctrl = 0 and out_valid = 0 over 10 edges.
